// File: rtl/nibble_bus_receiver.sv
// ============================================================================
// Module      : nibble_bus_receiver
// Description : Listening end of a 4-bit nibble bus. Pairs nibbles into bytes
//               and queues them in a FIFO behind a valid/ready output. The
//               optional saturating drop counter is NIBBLE_RX_DROP_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_bus_receiver #(
    parameter int DEPTH     = 4,
    parameter bit LSN_FIRST = 1'b1,
    parameter int TIMEOUT   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 inp,
    input  logic                       c,
    output logic [7:0]                 o,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       ovf,
    input  logic                       ovf_clr,
`ifdef NIBBLE_RX_DROP_CNT_EN
    output logic [7:0]                 drop_cnt,
`endif
    output logic                       frag_err
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HALF = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     first_q, first_d;
    logic [7:0]     tmo_q, tmo_d;
    logic [7:0]     tmo_inc;
    logic           frag_q, frag_d;
    logic           push_q, push_d;
    logic [7:0]     pbyte_q, pbyte_d;

    logic [7:0]     mem_q [DEPTH];
    logic [7:0]     mem_d [DEPTH];
    logic [AW:0]    wr_q, wr_d;
    logic [AW:0]    rd_q, rd_d;
    logic [AW:0]    level_q, level_d;
    logic           o_valid_q, o_valid_d;
    logic [7:0]     o_q, o_d;
    logic           ovf_q, ovf_d;

    logic           full;
    logic           pop;
    logic           wr_en;
    logic           drop;

    // Nibble pairing; the assembled byte is staged one cycle before the FIFO.
    always_comb begin
        state_d = state_q;
        first_d = first_q;
        tmo_d   = tmo_q;
        frag_d  = 1'b0;
        push_d  = 1'b0;
        pbyte_d = pbyte_q;
        tmo_inc = tmo_q + 8'd1;
        case (state_q)
            S_IDLE: begin
                if (c) begin
                    first_d = inp;
                    tmo_d   = 8'd0;
                    state_d = S_HALF;
                end
            end
            S_HALF: begin
                if (c) begin
                    push_d  = 1'b1;
                    pbyte_d = LSN_FIRST ? {inp, first_q} : {first_q, inp};
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == C_TIMEOUT) begin
                        frag_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO bookkeeping; a full FIFO still accepts a push when a pop frees a slot.
    always_comb begin
        full    = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
        pop     = o_valid_q & o_ready;
        wr_en   = push_q & (~full | pop);
        drop    = push_q & full & ~pop;
        mem_d   = mem_q;
        if (wr_en) begin
            mem_d[wr_q[AW-1:0]] = pbyte_q;
        end
        wr_d      = wr_q + {{AW{1'b0}}, wr_en};
        rd_d      = rd_q + {{AW{1'b0}}, pop};
        level_d   = wr_d - rd_d;
        o_valid_d = (wr_d != rd_d);
        o_d       = o_valid_d ? mem_d[rd_d[AW-1:0]] : o_q;
        ovf_d     = (ovf_q & ~ovf_clr) | drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            first_q   <= 4'h0;
            tmo_q     <= 8'd0;
            frag_q    <= 1'b0;
            push_q    <= 1'b0;
            pbyte_q   <= 8'h00;
            mem_q     <= '{default: 8'h00};
            wr_q      <= '0;
            rd_q      <= '0;
            level_q   <= '0;
            o_valid_q <= 1'b0;
            o_q       <= 8'h00;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            tmo_q     <= tmo_d;
            frag_q    <= frag_d;
            push_q    <= push_d;
            pbyte_q   <= pbyte_d;
            mem_q     <= mem_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            level_q   <= level_d;
            o_valid_q <= o_valid_d;
            o_q       <= o_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef NIBBLE_RX_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    assign o        = o_q;
    assign o_valid  = o_valid_q;
    assign level    = level_q;
    assign ovf      = ovf_q;
    assign frag_err = frag_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_bus_receiver.sv
// ============================================================================
// Module      : tb_nibble_bus_receiver
// Description : Scoreboard bench for nibble_bus_receiver (DEPTH=4, LSN first,
//               TIMEOUT=8); drop_cnt is checked when NIBBLE_RX_DROP_CNT_EN set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_bus_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] inp;
    logic       c;
    logic [7:0] o;
    logic       o_valid;
    logic       o_ready;
    logic [2:0] level;
    logic       ovf;
    logic       ovf_clr;
    logic       frag_err;
`ifdef NIBBLE_RX_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q [$];

    nibble_bus_receiver #(
        .DEPTH     (4),
        .LSN_FIRST (1'b1),
        .TIMEOUT   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .inp      (inp),
        .c        (c),
        .o        (o),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .level    (level),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
`ifdef NIBBLE_RX_DROP_CNT_EN
        .drop_cnt (drop_cnt),
`endif
        .frag_err (frag_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one bus cycle; returns 1 time unit after the sampling edge.
    task automatic step(input logic cv, input logic [3:0] nv);
        c   = cv;
        inp = nv;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit expect_kept);
        step(1'b1, b[3:0]);
        step(1'b1, b[7:4]);
        if (expect_kept) exp_q.push_back(b);
    endtask

    // Monitor: every handshake must deliver the oldest expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", int'(o), -1);
                end else begin
                    chk("pop_data", int'(o), int'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; c = 1'b0; inp = 4'h0; o_ready = 1'b0; ovf_clr = 1'b0;
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
        rst = 1'b0;
        chk("rst_level", int'(level), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_o", int'(o), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_frag", int'(frag_err), 0);

        // Single byte, 0xA5, with latency and one-cycle valid.
        o_ready = 1'b1;
        send_byte(8'hA5, 1'b1);
        chk("push_cycle_valid", int'(o_valid), 0);
        step(1'b0, 4'h0);
        chk("t1_valid", int'(o_valid), 1);
        chk("t1_level", int'(level), 1);
        step(1'b0, 4'h0);
        chk("t1_valid_drop", int'(o_valid), 0);
        chk("t1_level0", int'(level), 0);
        chk("t1_o_hold", int'(o), 8'hA5);

        // Overflow: five bytes into a 4-deep FIFO with no reader.
        o_ready = 1'b0;
        for (int k = 0; k < 5; k++) send_byte(8'h10 + 8'(k), k < 4);
        chk("t2_level_full", int'(level), 4);
        chk("t2_ovf_before", int'(ovf), 0);
        step(1'b0, 4'h0);
        chk("t2_level_kept", int'(level), 4);
        chk("t2_ovf_set", int'(ovf), 1);
`ifdef NIBBLE_RX_DROP_CNT_EN
        chk("t2_drop_cnt", int'(drop_cnt), 1);
`endif
        o_ready = 1'b1;
        repeat (5) step(1'b0, 4'h0);
        chk("t2_drained", int'(level), 0);

        // Clear with no overflow, then push into a full FIFO during a pop.
        ovf_clr = 1'b1;
        step(1'b0, 4'h0);
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", int'(ovf), 0);
        o_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_byte(8'h20 + 8'(k), 1'b1);
        step(1'b0, 4'h0);
        chk("t3_full", int'(level), 4);
        send_byte(8'h24, 1'b1);
        o_ready = 1'b1;
        step(1'b0, 4'h0);
        chk("t3_level_same", int'(level), 4);
        chk("t3_no_ovf", int'(ovf), 0);
        repeat (5) step(1'b0, 4'h0);
        chk("t3_drained", int'(level), 0);

        // Timeout after a lone nibble 0x3.
        step(1'b1, 4'h3);
        repeat (7) step(1'b0, 4'h0);
        chk("t4_frag_early", int'(frag_err), 0);
        step(1'b0, 4'h0);
        chk("t4_frag_pulse", int'(frag_err), 1);
        step(1'b1, 4'h1);
        chk("t4_frag_end", int'(frag_err), 0);
        step(1'b1, 4'h2);
        exp_q.push_back(8'h21);
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
        chk("t4_level", int'(level), 0);

        // Reset while holding a first nibble.
        step(1'b1, 4'h7);
        rst = 1'b1;
        step(1'b0, 4'h0);
        rst = 1'b0;
        chk("t5_level", int'(level), 0);
        chk("t5_valid", int'(o_valid), 0);
        chk("t5_ovf", int'(ovf), 0);
        chk("t5_frag", int'(frag_err), 0);
        step(1'b0, 4'h0);
        chk("t5_frag_late", int'(frag_err), 0);
        send_byte(8'hDC, 1'b1);
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);

        // Overflow coinciding with ovf_clr: set wins.
        o_ready = 1'b0;
        for (int k = 0; k < 5; k++) send_byte(8'h30 + 8'(k), k < 4);
        step(1'b0, 4'h0);
        chk("t6_ovf_set", int'(ovf), 1);
        send_byte(8'h35, 1'b0);
        ovf_clr = 1'b1;
        step(1'b0, 4'h0);
        chk("t6_set_wins", int'(ovf), 1);
        step(1'b0, 4'h0);
        chk("t6_clr", int'(ovf), 0);
        ovf_clr = 1'b0;
        chk("t6_level", int'(level), 4);
`ifdef NIBBLE_RX_DROP_CNT_EN
        chk("t6_drop_cnt", int'(drop_cnt), 2);
`endif
        o_ready = 1'b1;
        repeat (5) step(1'b0, 4'h0);
        chk("t6_drained", int'(level), 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
